// File: rtl/exception_ctrl.sv
// Commit-point exception/interrupt arbiter: picks the highest-priority event in
// writeback, pulses exception/eret to CP0, flushes, and holds a redirect for fetch.
module exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_is_delay_slot,
    input  logic [6:0]  wb_exc,
    input  logic        wb_eret,
    input  logic [31:0] wb_data_addr,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic        exception,
    output logic        eret,
    output logic [4:0]  excode,
    output logic [31:0] exc_pc,
    output logic        exc_is_delay_slot,
    output logic [31:0] badvaddr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_REDIRECT
    } state_t;

    state_t      state_q;
    logic        exception_q;
    logic        eret_q;
    logic [4:0]  excode_q;
    logic [31:0] exc_pc_q;
    logic        exc_ds_q;
    logic [31:0] badvaddr_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;

    logic        int_pend;
    logic        trap;
    logic        ret;
    logic [4:0]  excode_d;
    logic [31:0] badvaddr_d;

    logic        unused_cp0_bits;
    assign unused_cp0_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

    always_comb begin
        int_pend = cp0_status[0] & ~cp0_status[1] & (|(cp0_cause[15:8] & cp0_status[15:8]));
        trap     = (state_q == S_IDLE) & wb_valid & (int_pend | (|wb_exc));
        ret      = (state_q == S_IDLE) & wb_valid & wb_eret & ~trap;

        excode_d   = 5'd0;
        badvaddr_d = '0;
        if (int_pend) begin
            excode_d = 5'd0;
        end else if (wb_exc[0]) begin
            excode_d   = 5'd4;
            badvaddr_d = wb_pc;
        end else if (wb_exc[1]) begin
            excode_d = 5'd10;
        end else if (wb_exc[2]) begin
            excode_d = 5'd12;
        end else if (wb_exc[3]) begin
            excode_d = 5'd8;
        end else if (wb_exc[4]) begin
            excode_d = 5'd9;
        end else if (wb_exc[5]) begin
            excode_d   = 5'd4;
            badvaddr_d = wb_data_addr;
        end else if (wb_exc[6]) begin
            excode_d   = 5'd5;
            badvaddr_d = wb_data_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            exception_q      <= 1'b0;
            eret_q           <= 1'b0;
            excode_q         <= '0;
            exc_pc_q         <= '0;
            exc_ds_q         <= 1'b0;
            badvaddr_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    exception_q <= 1'b0;
                    eret_q      <= 1'b0;
                    if (trap || ret) begin
                        state_q       <= S_ISSUE;
                        exception_q   <= trap;
                        eret_q        <= ret;
                        excode_q      <= excode_d;
                        exc_pc_q      <= wb_pc;
                        exc_ds_q      <= wb_is_delay_slot;
                        badvaddr_q    <= badvaddr_d;
                        redirect_pc_q <= trap ? EXC_VECTOR : cp0_epc;
                    end
                end
                S_ISSUE: begin
                    exception_q      <= 1'b0;
                    eret_q           <= 1'b0;
                    redirect_valid_q <= 1'b1;
                    state_q          <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid_q <= 1'b0;
                        state_q          <= S_IDLE;
                    end
                end
                default: begin
                    state_q          <= S_IDLE;
                    exception_q      <= 1'b0;
                    eret_q           <= 1'b0;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Flush is combinational in the event cycle so the committing write is killed.
    assign flush             = (state_q != S_IDLE) | trap | ret;
    assign exception         = exception_q;
    assign eret              = eret_q;
    assign excode            = excode_q;
    assign exc_pc            = exc_pc_q;
    assign exc_is_delay_slot = exc_ds_q;
    assign badvaddr          = badvaddr_q;
    assign redirect_valid    = redirect_valid_q;
    assign redirect_pc       = redirect_pc_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed vector bench for exception_ctrl: event table plus backpressure and reset sequences.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_is_delay_slot;
    logic [6:0]  wb_exc;
    logic        wb_eret;
    logic [31:0] wb_data_addr;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        exception;
    logic        eret;
    logic [4:0]  excode;
    logic [31:0] exc_pc;
    logic        exc_is_delay_slot;
    logic [31:0] badvaddr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int unsigned errors = 0;
    int unsigned checks = 0;

    exception_ctrl #(.EXC_VECTOR(32'hBFC00380)) dut (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_is_delay_slot(wb_is_delay_slot), .wb_exc(wb_exc), .wb_eret(wb_eret),
        .wb_data_addr(wb_data_addr), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
        .cp0_epc(cp0_epc), .exception(exception), .eret(eret), .excode(excode),
        .exc_pc(exc_pc), .exc_is_delay_slot(exc_is_delay_slot), .badvaddr(badvaddr),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    // kind: 0 = no event, 1 = exception, 2 = eret
    typedef struct {
        logic        valid;
        logic [6:0]  exc;
        logic        er;
        logic        ds;
        logic [31:0] pc;
        logic [31:0] daddr;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [1:0]  kind;
        logic [4:0]  code;
        logic [31:0] bva;
        logic [31:0] rpc;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 0; wb_exc = '0; wb_eret = 0; wb_is_delay_slot = 0;
        wb_pc = '0; wb_data_addr = '0; cp0_status = '0; cp0_cause = '0; cp0_epc = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " exception"}, {31'd0, exception}, 0);
        check({tag, " eret"}, {31'd0, eret}, 0);
        check({tag, " flush"}, {31'd0, flush}, 0);
        check({tag, " redirect_valid"}, {31'd0, redirect_valid}, 0);
        check({tag, " excode"}, {27'd0, excode}, 0);
        check({tag, " exc_pc"}, exc_pc, 0);
        check({tag, " redirect_pc"}, redirect_pc, 0);
        check({tag, " badvaddr"}, badvaddr, 0);
        check({tag, " exc_ds"}, {31'd0, exc_is_delay_slot}, 0);
    endtask

    // Drives one event cycle starting just after a posedge in IDLE.
    task automatic fire_sys(input logic [31:0] pc);
        wb_valid = 1; wb_exc = 7'b0001000; wb_pc = pc; wb_eret = 0;
        cp0_status = '0; cp0_cause = '0;
    endtask

    initial begin
        logic [31:0] held_rpc;

        vecs[0]  = '{1, 7'b0001000, 0, 0, 32'h80001000, 32'h0,        32'h0,      32'h0,    32'h0,        1, 5'd8,  32'h0,        32'hBFC00380};
        vecs[1]  = '{1, 7'b0100010, 0, 1, 32'h80001100, 32'h00000003, 32'h0,      32'h0,    32'h0,        1, 5'd10, 32'h0,        32'hBFC00380};
        vecs[2]  = '{1, 7'b1000000, 0, 0, 32'h80001200, 32'h00000003, 32'h0,      32'h0,    32'h0,        1, 5'd5,  32'h00000003, 32'hBFC00380};
        vecs[3]  = '{1, 7'b0000101, 0, 0, 32'h80004000, 32'h0000dead, 32'h0,      32'h0,    32'h0,        1, 5'd4,  32'h80004000, 32'hBFC00380};
        vecs[4]  = '{1, 7'b0000000, 0, 0, 32'h80001300, 32'h0,        32'h00008003, 32'h8000, 32'h0,      0, 5'd0,  32'h0,        32'h0};
        vecs[5]  = '{1, 7'b0000000, 1, 0, 32'h80002000, 32'h0,        32'h00008001, 32'h8000, 32'h80005555, 1, 5'd0, 32'h0,       32'hBFC00380};
        vecs[6]  = '{1, 7'b0000000, 1, 1, 32'h80002100, 32'h0,        32'h0,      32'h0,    32'h80003004, 2, 5'd0,  32'h0,        32'h80003004};
        vecs[7]  = '{1, 7'b0000100, 0, 0, 32'h80002200, 32'h0,        32'h0,      32'h0,    32'h0,        1, 5'd12, 32'h0,        32'hBFC00380};
        vecs[8]  = '{1, 7'b0010000, 1, 0, 32'h80002300, 32'h0,        32'h0,      32'h0,    32'h80009999, 1, 5'd9, 32'h0,        32'hBFC00380};
        vecs[9]  = '{1, 7'b0100000, 0, 0, 32'h80002400, 32'h00001234, 32'h0,      32'h0,    32'h0,        1, 5'd4,  32'h00001234, 32'hBFC00380};
        vecs[10] = '{1, 7'b1100100, 0, 0, 32'h80002500, 32'h00001234, 32'h00000401, 32'h0400, 32'h0,      1, 5'd0,  32'h0,        32'hBFC00380};
        vecs[11] = '{1, 7'b0000100, 0, 0, 32'h80002600, 32'h0,        32'h00008003, 32'h8000, 32'h0,      1, 5'd12, 32'h0,        32'hBFC00380};
        vecs[12] = '{1, 7'b0000000, 0, 0, 32'h80002700, 32'h0,        32'h00000101, 32'h8000, 32'h0,      0, 5'd0,  32'h0,        32'h0};
        vecs[13] = '{0, 7'b0001000, 1, 0, 32'h80002800, 32'h0,        32'h00008001, 32'h8000, 32'h0,      0, 5'd0,  32'h0,        32'h0};

        idle_inputs();
        redirect_ready = 1;
        reset = 1;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 0;

        for (int i = 0; i < NV; i++) begin
            wb_valid = vecs[i].valid; wb_exc = vecs[i].exc; wb_eret = vecs[i].er;
            wb_is_delay_slot = vecs[i].ds; wb_pc = vecs[i].pc; wb_data_addr = vecs[i].daddr;
            cp0_status = vecs[i].status; cp0_cause = vecs[i].cause; cp0_epc = vecs[i].epc;
            redirect_ready = 1;
            #1;
            check($sformatf("v%0d flushN", i), {31'd0, flush}, {31'd0, vecs[i].kind != 0});
            tick();
            idle_inputs();
            #1;
            if (vecs[i].kind == 0) begin
                check($sformatf("v%0d no_exc", i), {31'd0, exception}, 0);
                check($sformatf("v%0d no_eret", i), {31'd0, eret}, 0);
                check($sformatf("v%0d no_flush", i), {31'd0, flush}, 0);
            end else begin
                check($sformatf("v%0d exception", i), {31'd0, exception}, {31'd0, vecs[i].kind == 1});
                check($sformatf("v%0d eret", i), {31'd0, eret}, {31'd0, vecs[i].kind == 2});
                if (vecs[i].kind == 1)
                    check($sformatf("v%0d excode", i), {27'd0, excode}, {27'd0, vecs[i].code});
                check($sformatf("v%0d exc_pc", i), exc_pc, vecs[i].pc);
                check($sformatf("v%0d exc_ds", i), {31'd0, exc_is_delay_slot}, {31'd0, vecs[i].ds});
                check($sformatf("v%0d badvaddr", i), badvaddr, vecs[i].bva);
                check($sformatf("v%0d flush1", i), {31'd0, flush}, 1);
                tick();
                check($sformatf("v%0d pulse_end", i), {31'd0, exception | eret}, 0);
                check($sformatf("v%0d rvalid", i), {31'd0, redirect_valid}, 1);
                check($sformatf("v%0d rpc", i), redirect_pc, vecs[i].rpc);
                check($sformatf("v%0d flush2", i), {31'd0, flush}, 1);
                tick();
                check($sformatf("v%0d rvalid_done", i), {31'd0, redirect_valid}, 0);
                check($sformatf("v%0d flush_done", i), {31'd0, flush}, 0);
            end
        end

        // Redirect backpressure with a second Sys arriving while busy
        redirect_ready = 0;
        fire_sys(32'h80007000);
        tick();
        idle_inputs();
        check("bp exception", {31'd0, exception}, 1);
        tick();
        held_rpc = 32'hBFC00380;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) fire_sys(32'h80007100);
            check($sformatf("bp%0d rvalid", c), {31'd0, redirect_valid}, 1);
            check($sformatf("bp%0d flush", c), {31'd0, flush}, 1);
            check($sformatf("bp%0d rpc", c), redirect_pc, held_rpc);
            check($sformatf("bp%0d no_pulse", c), {31'd0, exception}, 0);
            check($sformatf("bp%0d exc_pc", c), exc_pc, 32'h80007000);
            tick();
            idle_inputs();
        end
        redirect_ready = 1;
        #1;
        check("bp accept rvalid", {31'd0, redirect_valid}, 1);
        tick();
        check("bp idle rvalid", {31'd0, redirect_valid}, 0);
        check("bp idle flush", {31'd0, flush}, 0);
        tick();
        check("bp no stray exc", {31'd0, exception}, 0);

        // Reset while in REDIRECT
        redirect_ready = 0;
        fire_sys(32'h80008000);
        tick();
        idle_inputs();
        tick();
        tick();
        check("rst pre rvalid", {31'd0, redirect_valid}, 1);
        reset = 1;
        tick();
        check_reset_outputs("rst mid");
        reset = 0;
        redirect_ready = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rst post%0d exc", c), {31'd0, exception}, 0);
            check($sformatf("rst post%0d rvalid", c), {31'd0, redirect_valid}, 0);
            check($sformatf("rst post%0d flush", c), {31'd0, flush}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Commit-point exception/interrupt arbiter for the mipsel32 pipeline: the initiator side of the CP0 exception interface. Samples the instruction committing in writeback together with its exception flags, the CP0 Status/Cause/EPC values, and pending interrupts. Selects the highest-priority event and issues a one-cycle exception or eret pulse to CP0 with excode, pc, delay-slot flag and badvaddr. Flushes the pipeline and holds a PC redirect to fetch until fetch accepts it.

## Interface
Parameters:
- EXC_VECTOR, 32'hBFC00380, exception entry PC (Status.BEV fixed at 1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  instruction is committing this cycle.
- wb_pc  in  32  PC of committing instruction.
- wb_is_delay_slot  in  1  committing instruction sits in a branch delay slot.
- wb_exc  in  7  exception flags: [0] AdEL-fetch, [1] RI, [2] Ov, [3] Sys, [4] Bp, [5] AdEL-data, [6] AdES.
- wb_eret  in  1  committing instruction is ERET.
- wb_data_addr  in  32  faulting data address for [5]/[6].
- cp0_status  in  32  CP0 Status; uses IM [15:8], EXL [1], IE [0].
- cp0_cause  in  32  CP0 Cause; uses IP [15:8].
- cp0_epc  in  32  CP0 EPC.
- exception  out  1  one-cycle pulse to CP0.
- eret  out  1  one-cycle pulse to CP0.
- excode  out  5  exception code to CP0.
- exc_pc  out  32  pc to CP0.
- exc_is_delay_slot  out  1  delay-slot flag to CP0.
- badvaddr  out  32  bad virtual address to CP0.
- flush  out  1  kill all in-flight instructions, including the committing one.
- redirect_valid  out  1  redirect PC offered to fetch.
- redirect_pc  out  32  target PC.
- redirect_ready  in  1  fetch accepts the redirect.

## Operation
- FSM states: IDLE, ISSUE, REDIRECT.
- Interrupt pending: int_pend = IE & ~EXL & |(IP & IM).
- Event in IDLE:
  - trap = wb_valid & (int_pend | |wb_exc).
  - ret = wb_valid & wb_eret & ~trap.
- Priority, highest first, with excode:
  - Int 0
  - AdEL-fetch 4
  - RI 10
  - Ov 12
  - Sys 8
  - Bp 9
  - AdEL-data 4
  - AdES 5
- badvaddr value:
  - AdEL-fetch: wb_pc.
  - AdEL-data or AdES (and no higher-priority event): wb_data_addr.
  - Otherwise: 32'd0.
- IDLE → ISSUE on trap or ret.
  - Latch excode, wb_pc, wb_is_delay_slot and badvaddr.
  - Latch redirect_pc = EXC_VECTOR for trap, cp0_epc for ret. EPC is sampled in the event cycle.
- ISSUE → REDIRECT unconditionally after one cycle.
- REDIRECT → IDLE in the cycle redirect_valid & redirect_ready.
- Outside IDLE, wb_valid and all wb_* inputs are ignored; the pipeline is being flushed.
- Simultaneous events:
  - An exception flag together with ERET means exception wins.
  - An interrupt together with any flag means the interrupt wins; EPC is the committing PC.
- EXL = 1 suppresses interrupts only; synchronous exceptions are still taken.

## Timing
- Reset values: state IDLE; exception, eret, flush and redirect_valid = 0; excode = 0; exc_pc, redirect_pc and badvaddr = 0; exc_is_delay_slot = 0.
- Event cycle N (IDLE):
  - flush = 1, combinational from trap|ret, so the committing instruction's regfile/memory write is suppressed.
- Cycle N+1 (ISSUE):
  - exactly one of exception or eret = 1, registered, for exactly one cycle.
  - excode, exc_pc, exc_is_delay_slot and badvaddr are valid and stable.
  - flush = 1.
- Cycles N+2 onward (REDIRECT):
  - redirect_valid = 1 and flush = 1.
  - redirect_pc is held stable until accepted.
- Acceptance cycle: the first REDIRECT cycle in which redirect_ready = 1.
  - In the following cycle: state IDLE, flush = 0, redirect_valid = 0.
  - Back-to-back minimum: a new event can be taken 3 cycles after the previous event cycle.
- redirect_ready is ignored outside REDIRECT.
- Reset asserted in any state returns the block to IDLE with reset values next cycle. A pending pulse or redirect is dropped.

## Test plan
- Syscall, no delay slot: wb_valid=1, wb_exc=7'b0001000, wb_pc=32'h80001000, ready=1 → cycle N flush=1; N+1 exception=1, excode=8, exc_pc=32'h80001000; N+2 redirect_pc=32'hBFC00380; N+3 IDLE.
- Priority and badvaddr: wb_exc=7'b0100010 (RI + AdEL-data), wb_data_addr=32'h00000003 → excode=10, badvaddr=0. Then wb_exc=7'b1000000 alone → excode=5, badvaddr=32'h00000003.
- Interrupt gating: IE=1, IM=8'h80, IP=8'h80.
  - EXL=1 → no event.
  - EXL=0 with ERET committing at 32'h80002000 → exception=1, excode=0, eret=0, exc_pc=32'h80002000.
- ERET: cp0_epc=32'h80003004, wb_eret=1, no flags or interrupt → eret pulse one cycle; redirect_pc=32'h80003004.
- Redirect backpressure: redirect_ready=0 for 5 cycles → redirect_valid/flush held, redirect_pc stable, a second wb_valid+Sys ignored. Then ready=1 → IDLE next cycle.
- Reset mid-REDIRECT: reset=1 → next cycle all outputs 0; no exception pulse after reset deasserts.
